// File: rtl/and3_exhaustive_checker.sv
// rtl/and3_exhaustive_checker.sv - exhaustive stimulus/response checker for a 3-input AND gate
// Walks all eight {x,y,w} vectors, samples z at the end of each hold window, and reports the results.
module and3_exhaustive_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             x,
  output logic             y,
  output logic             w,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       first_fail_vec
);

  localparam int HCW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [2:0]     vec;
  logic [HCW-1:0] hold_cnt;
  logic           expected;
  logic           mismatch;

  assign expected = &vec;
  // X or Z on z never matches a 1, so an undriven gate output counts as a failure
  assign mismatch = !((z === 1'b1) == expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      vec            <= 3'd0;
      hold_cnt       <= '0;
      x              <= 1'b0;
      y              <= 1'b0;
      w              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= 3'd0;
    end else begin
      // Status and gate drive lag the state by one edge so vector 0 lands together with busy
      x    <= vec[2];
      y    <= vec[1];
      w    <= vec[0];
      busy <= (state == RUN);
      done <= (state == DONE);
      pass <= (state == DONE) && (err_count == '0);

      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec            <= 3'd0;
            hold_cnt       <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= 3'd0;
            state          <= RUN;
          end
        end
        RUN: begin
          if (hold_cnt == HOLD_LAST) begin
            if (mismatch) begin
              if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + 1'b1;
              end
              if (!fail_valid) begin
                first_fail_vec <= vec;
                fail_valid     <= 1'b1;
              end
            end
            if (vec == 3'd7) begin
              state <= DONE;
            end else begin
              vec      <= vec + 3'd1;
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and3_exhaustive_checker.sv
// tb/tb_and3_exhaustive_checker.sv - randomized self-checking bench for and3_exhaustive_checker
// Two instances (HOLD_CYCLES=4/ERR_W=4 and HOLD_CYCLES=2/ERR_W=2) check a gate modelled by a truth table.
module tb_and3_exhaustive_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tt    = 8'h80;

  logic       xa, ya, wa, za, busy_a, done_a, pass_a, fv_a;
  logic [3:0] err_a;
  logic [2:0] ffv_a;
  logic       xb, yb, wb, zb, busy_b, done_b, pass_b, fv_b;
  logic [1:0] err_b;
  logic [2:0] ffv_b;

  assign za = tt[{xa, ya, wa}];
  assign zb = tt[{xb, yb, wb}];

  and3_exhaustive_checker #(.HOLD_CYCLES(4), .ERR_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .x(xa), .y(ya), .w(wa), .z(za),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_valid(fv_a), .first_fail_vec(ffv_a)
  );

  and3_exhaustive_checker #(.HOLD_CYCLES(2), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .x(xb), .y(yb), .w(wb), .z(zb),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_valid(fv_b), .first_fail_vec(ffv_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_xyw_a", 32'({xa, ya, wa}), 0);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_done_a", 32'(done_a), 0);
    check("rst_pass_a", 32'(pass_a), 0);
    check("rst_err_a", 32'(err_a), 0);
    check("rst_fv_a", 32'(fv_a), 0);
    check("rst_ffv_a", 32'(ffv_a), 0);
    check("rst_all_b", 32'({xb, yb, wb, busy_b, done_b, pass_b, err_b, fv_b, ffv_b}), 0);
  endtask

  // Pulses start, follows instance A cycle by cycle, then compares both against the truth-table model.
  // rst_at > 0 asserts reset at that cycle of the sweep and checks the abort instead.
  task automatic run_sweep(input logic [7:0] tt_in, input bit poke_start, input int rst_at);
    int errs  = 0;
    int first = 0;
    bit fv    = 0;
    for (int v = 0; v < 8; v++) begin
      if (tt_in[v] != (v == 7)) begin
        if (!fv) first = v;
        fv = 1;
        errs++;
      end
    end
    tt = tt_in;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (rst_at == c) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("idle_busy", 32'({busy_a, busy_b, done_a, done_b}), 0);
        end
        return;
      end
      if (c <= 32) begin
        check("run_busy_a", 32'(busy_a), 1);
        check("run_done_a", 32'({done_a, pass_a}), 0);
        check("run_xyw_a", 32'({xa, ya, wa}), 32'((c - 1) / 4));
      end else begin
        check("end_busy_a", 32'(busy_a), 0);
        check("end_done_a", 32'(done_a), 1);
        check("end_xyw_a", 32'({xa, ya, wa}), 7);
      end
      if (poke_start) start = (c == 10);
    end
    check("pass_a", 32'(pass_a), 32'(errs == 0));
    check("err_a", 32'(err_a), 32'((errs > 15) ? 15 : errs));
    check("fv_a", 32'(fv_a), 32'(fv));
    check("ffv_a", 32'(ffv_a), 32'(first));
    check("done_b", 32'({done_b, busy_b}), 2);
    check("pass_b", 32'(pass_b), 32'(errs == 0));
    check("err_b", 32'(err_b), 32'((errs > 3) ? 3 : errs));
    check("fv_b", 32'(fv_b), 32'(fv));
    check("ffv_b", 32'(ffv_b), 32'(first));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();

    run_sweep(8'h80, 0, 0);
    run_sweep(8'h00, 0, 0);
    run_sweep(8'hFF, 0, 0);
    run_sweep(8'h7F, 0, 0);
    run_sweep(8'h80, 1, 0);
    run_sweep(8'h80, 0, 14);
    run_sweep(8'h80, 0, 0);
    repeat (8) begin
      run_sweep(8'($urandom), bit'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
